// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector MAC controller: FSM state
// encoding and the MAC pipeline depth seen from the read strobe.
package mv_pkg;

    // Memory read (1) plus MAC pipeline stages (2) between MEM_RD and accumulate.
    localparam int unsigned MAC_PIPE_DEPTH = 3;
    localparam int unsigned DRAIN_W        = $clog2(MAC_PIPE_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/mac_en_pipe.sv
// Delays the memory read strobe by the MAC pipeline depth so the
// accumulate enable lines up with the product of each issued element.
// Ports: i_clk, i_rst_n (async, active-low), i_mem_rd -> o_acc_en.
module mac_en_pipe
    import mv_pkg::*;
#(
    parameter int unsigned DEPTH = MAC_PIPE_DEPTH
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_mem_rd,
    output logic o_acc_en
);

    logic [DEPTH-1:0] r_pipe;

    // Shift register, cleared asynchronously so an aborted row never accumulates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= {r_pipe[DEPTH-2:0], i_mem_rd};
        end
    end

    assign o_acc_en = r_pipe[DEPTH-1];

endmodule

// File: rtl/mv_mac_ctrl.sv
// Matrix-vector multiply sequencer driving an external MAC slice.
// For each row: clear the accumulator, stream ROW_LEN weight/vector
// reads, let the MAC pipeline drain, then offer the row sum on a
// valid/ready result port.
// Ports: CLK/RSTN; START, NUM_ROWS, ROW_LEN job request; BUSY, DONE status;
// MEM_RD, W_ADDR, X_ADDR memory reads; DSP_EN, DSP_ACC_EN, DSP_RSTN,
// DSP_OUT MAC control/value; RES_VALID, RES_READY, RES_DATA, RES_ROW results.
module mv_mac_ctrl
    import mv_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned WIDTH_OUT = 48
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START,
    input  logic [LEN_W-1:0]     NUM_ROWS,
    input  logic [LEN_W-1:0]     ROW_LEN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 MEM_RD,
    output logic [ADDR_W-1:0]    W_ADDR,
    output logic [ADDR_W-1:0]    X_ADDR,
    output logic                 DSP_EN,
    output logic                 DSP_ACC_EN,
    output logic                 DSP_RSTN,
    input  logic [WIDTH_OUT-1:0] DSP_OUT,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [WIDTH_OUT-1:0] RES_DATA,
    output logic [LEN_W-1:0]     RES_ROW
);

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_rows, r_len, r_row, r_k;
    logic [LEN_W-1:0]   w_rows_nxt, w_len_nxt, w_row_nxt, w_k_nxt;
    logic [DRAIN_W-1:0] r_drain, w_drain_nxt;
    logic [ADDR_W-1:0]  r_base, r_w_addr, r_x_addr;
    logic [ADDR_W-1:0]  w_base_nxt, w_w_addr_nxt, w_x_addr_nxt;
    logic               r_busy, r_done, r_mem_rd, r_dsp_en, r_dsp_rstn, r_res_valid;
    logic               w_busy_nxt, w_done_nxt, w_mem_rd_nxt, w_dsp_en_nxt;
    logic               w_dsp_rstn_nxt, w_res_valid_nxt;

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, job counters and addresses; outputs decoded from the next state
    // so every control output is registered yet aligned with its state.
    always_comb begin
        w_state_nxt  = r_state;
        w_rows_nxt   = r_rows;
        w_len_nxt    = r_len;
        w_row_nxt    = r_row;
        w_k_nxt      = r_k;
        w_drain_nxt  = r_drain;
        w_base_nxt   = r_base;
        w_w_addr_nxt = r_w_addr;
        w_x_addr_nxt = r_x_addr;
        w_done_nxt   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_rows_nxt = NUM_ROWS;
                    w_len_nxt  = ROW_LEN;
                    w_row_nxt  = '0;
                    w_base_nxt = '0;
                    if (NUM_ROWS != '0) begin
                        w_state_nxt = ST_CLR;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_CLR: begin
                w_k_nxt     = '0;
                w_drain_nxt = '0;
                if (r_len == '0) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt  = ST_ISSUE;
                    w_w_addr_nxt = r_base;
                    w_x_addr_nxt = '0;
                end
            end
            ST_ISSUE: begin
                if (r_k == r_len - LEN_W'(1)) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_k_nxt      = r_k + LEN_W'(1);
                    w_w_addr_nxt = r_w_addr + ADDR_W'(1);
                    w_x_addr_nxt = r_x_addr + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (r_drain == DRAIN_W'(MAC_PIPE_DEPTH - 1)) begin
                    w_state_nxt = ST_RESULT;
                end else begin
                    w_drain_nxt = r_drain + DRAIN_W'(1);
                end
            end
            ST_RESULT: begin
                if (RES_READY) begin
                    if (r_row == r_rows - LEN_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_CLR;
                        w_row_nxt   = r_row + LEN_W'(1);
                        // Running row base replaces row*ROW_LEN.
                        w_base_nxt  = r_base + ADDR_W'(r_len);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_mem_rd_nxt    = (w_state_nxt == ST_ISSUE);
        w_dsp_en_nxt    = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
        w_dsp_rstn_nxt  = (w_state_nxt != ST_CLR);
        w_res_valid_nxt = (w_state_nxt == ST_RESULT);
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rows      <= '0;
            r_len       <= '0;
            r_row       <= '0;
            r_k         <= '0;
            r_drain     <= '0;
            r_base      <= '0;
            r_w_addr    <= '0;
            r_x_addr    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_dsp_en    <= 1'b0;
            r_dsp_rstn  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_rows      <= w_rows_nxt;
            r_len       <= w_len_nxt;
            r_row       <= w_row_nxt;
            r_k         <= w_k_nxt;
            r_drain     <= w_drain_nxt;
            r_base      <= w_base_nxt;
            r_w_addr    <= w_w_addr_nxt;
            r_x_addr    <= w_x_addr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_dsp_en    <= w_dsp_en_nxt;
            r_dsp_rstn  <= w_dsp_rstn_nxt;
            r_res_valid <= w_res_valid_nxt;
        end
    end

    mac_en_pipe #(
        .DEPTH    (MAC_PIPE_DEPTH)
    ) u_mac_en_pipe (
        .i_clk    (CLK),
        .i_rst_n  (RSTN),
        .i_mem_rd (r_mem_rd),
        .o_acc_en (DSP_ACC_EN)
    );

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign MEM_RD    = r_mem_rd;
    assign W_ADDR    = r_w_addr;
    assign X_ADDR    = r_x_addr;
    assign DSP_EN    = r_dsp_en;
    assign DSP_RSTN  = r_dsp_rstn;
    assign RES_VALID = r_res_valid;
    assign RES_ROW   = r_row;
    // The accumulator settles on the edge that enters RESULT and is frozen
    // there (no accumulate, no clear), so it is presented directly.
    assign RES_DATA  = r_res_valid ? DSP_OUT : '0;

endmodule
